fetch_pc_sequencer: RTL and testbench

Instruction-fetch PC sequencer: owns the architectural program counter and consumes the jump targets produced by the execute-stage jump/branch units (JAL, JALR, branches). Issues one instruction-memory request at a time, delivers fetched words with their PC to decode, and redirects on a jump. Clears target bit 0 per RV32I JALR semantics and flags misaligned targets. Sits between the execute-stage control-transfer ALUs and the decode stage.

---
 rtl/fetch_pc_sequencer_if.sv | 38 +++
 rtl/fetch_pc_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fetch_pc_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_sequencer_if.sv
// Bundle of the sequencer's redirect, instruction-memory and decode-side signals.
// master = sequencer side, slave = execute/memory/decode environment side.
interface fetch_pc_sequencer_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        misalign_fault;
    logic [31:0] misalign_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_ready,
        output imem_req_valid, imem_addr,
        output instr_valid, instr, instr_pc,
        output misalign_fault, misalign_pc
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_ready,
        input  imem_req_valid, imem_addr,
        input  instr_valid, instr, instr_pc,
        input  misalign_fault, misalign_pc
    );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// Instruction-fetch PC sequencer: one outstanding imem request, redirect/kill handling.
// Define FETCH_MISALIGN_TRAP_EN to trap on redirect targets with bit 1 set.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    fetch_pc_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] target_q, target_d;
    logic        kill_q, kill_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        req_valid_q, req_valid_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] redir_tgt;
    logic        accept;
    logic        kill_eff;
    logic [31:0] tgt_eff;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic        redir_trap;

    // Only bit 0 is cleared here; a set bit 1 is reported rather than repaired.
    assign redir_tgt  = bus.redirect_pc & 32'hFFFF_FFFE;
    assign redir_trap = bus.redirect_valid & bus.redirect_pc[1];
`else
    assign redir_tgt  = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

    assign accept   = req_valid_q & bus.imem_req_ready;
    // A redirect arriving in the same cycle as the response also kills it and wins.
    assign kill_eff = kill_q | bus.redirect_valid;
    assign tgt_eff  = bus.redirect_valid ? redir_tgt : target_q;

    // NOTE: every signal gets its default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        kill_d     = kill_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
`endif

        unique case (state_q)
            S_FETCH: begin
                if (bus.redirect_valid) begin
                    target_d = redir_tgt;
                    kill_d   = 1'b1;
                end
                if (accept) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    target_d = redir_tgt;
                    kill_d   = 1'b1;
                end
                if (bus.imem_rsp_valid) begin
                    if (kill_eff) begin
                        fetch_pc_d = tgt_eff;
                        kill_d     = 1'b0;
                        state_d    = S_FETCH;
                    end else begin
                        instr_d    = bus.imem_rsp_data;
                        instr_pc_d = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    fetch_pc_d = redir_tgt;
                    state_d    = S_FETCH;
                end else if (bus.instr_ready) begin
                    state_d    = S_FETCH;
                end
            end
            S_FAULT: begin
            end
            default: state_d = S_FETCH;
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        if (redir_trap && (state_q != S_FAULT)) begin
            state_d    = S_FAULT;
            kill_d     = 1'b0;
            fault_d    = 1'b1;
            fault_pc_d = redir_tgt;
        end
`endif

        req_valid_d   = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_HOLD);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= S_FETCH;
            fetch_pc_q    <= RESET_PC;
            target_q      <= '0;
            kill_q        <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            target_q      <= target_d;
            kill_q        <= kill_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    assign bus.misalign_fault = fault_q;
    assign bus.misalign_pc    = fault_pc_q;
`else
    assign bus.misalign_fault = 1'b0;
    assign bus.misalign_pc    = 32'h0000_0000;
`endif

    // fetch_pc_q always holds the presented address, so it drives imem_addr directly.
    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = fetch_pc_q;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.instr          = instr_q;
    assign bus.instr_pc       = instr_pc_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: sequential fetch, redirects in HOLD/WAIT,
// misalignment handling (follows FETCH_MISALIGN_TRAP_EN), PC wrap and mid-run reset.
module tb_fetch_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] DATA_KEY = 32'hDEAD_BEEF;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   mem_wait = 0;

    fetch_pc_sequencer_if bus ();

    fetch_pc_sequencer #(.RESET_PC(RESET_PC)) dut (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    // Memory model: one response per accepted request, mem_wait extra cycles after
    // the zero-wait slot; word returned is address ^ DATA_KEY.
    logic        acc_flag  = 1'b0;
    logic [31:0] acc_addr  = '0;
    logic [31:0] pend_addr = '0;
    logic        pending   = 1'b0;
    int          cnt       = 0;

    always @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_flag = 1'b0;
            pending  = 1'b0;
            cnt      = 0;
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end else begin
            bus.imem_rsp_valid = 1'b0;
            if (acc_flag) begin
                pending   = 1'b1;
                cnt       = mem_wait;
                pend_addr = acc_addr;
            end
            if (pending) begin
                if (cnt == 0) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = pend_addr ^ DATA_KEY;
                    pending = 1'b0;
                end else begin
                    cnt--;
                end
            end
            acc_flag = bus.imem_req_valid && bus.imem_req_ready;
            acc_addr = bus.imem_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_instr(input logic [31:0] pc, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.instr_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({tag, "_pc"}, bus.instr_pc, pc);
            check({tag, "_data"}, bus.instr, pc ^ DATA_KEY);
        end
    endtask

    task automatic wait_req(input logic [31:0] addr, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.imem_req_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) check({tag, "_addr"}, bus.imem_addr, addr);
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic do_reset(input logic ready);
        @(negedge clock);
        reset_n            = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.instr_ready    = ready;
        mem_wait           = 0;
        #1;
        check("rst_req_valid",   {31'd0, bus.imem_req_valid}, 32'd0);
        check("rst_addr",        bus.imem_addr, RESET_PC);
        check("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr",       bus.instr, 32'd0);
        check("rst_instr_pc",    bus.instr_pc, 32'd0);
        check("rst_fault",       {31'd0, bus.misalign_fault}, 32'd0);
        check("rst_fault_pc",    bus.misalign_pc, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("first_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
        check("first_req_addr",  bus.imem_addr, RESET_PC);
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;

        // Sequential fetch with zero-wait memory and an always-ready decoder.
        do_reset(1'b1);
        wait_instr(32'h0000_0100, "seq0");
        wait_instr(32'h0000_0104, "seq1");
        wait_instr(32'h0000_0108, "seq2");
        check("seq_no_fault", {31'd0, bus.misalign_fault}, 32'd0);

        // Reset mid-run, then redirect to 0x2001 while 0x104 is held in HOLD.
        do_reset(1'b1);
        wait_instr(32'h0000_0100, "hold0");
        @(negedge clock);
        bus.instr_ready = 1'b0;
        wait_instr(32'h0000_0104, "hold1");
        pulse_redirect(32'h0000_2001);
        check("hold_redir_drop",  {31'd0, bus.instr_valid}, 32'd0);
        check("hold_redir_req",   {31'd0, bus.imem_req_valid}, 32'd1);
        check("hold_redir_addr",  bus.imem_addr, 32'h0000_2000);
        bus.instr_ready = 1'b1;
        wait_instr(32'h0000_2000, "hold_tgt");

        // Redirect to 0x400 while the 0x108 response is outstanding.
        do_reset(1'b1);
        wait_instr(32'h0000_0100, "wait0");
        wait_instr(32'h0000_0104, "wait1");
        mem_wait = 2;
        wait_req(32'h0000_0108, "wait_req108");
        @(negedge clock);
        pulse_redirect(32'h0000_0400);
        mem_wait = 0;
        wait_req(32'h0000_0400, "wait_req400");
        wait_instr(32'h0000_0400, "wait_tgt");

        // Two redirects during a 5-cycle memory wait: the newest one wins.
        mem_wait = 5;
        wait_req(32'h0000_0404, "two_req404");
        @(negedge clock);
        pulse_redirect(32'h0000_0500);
        pulse_redirect(32'h0000_0600);
        mem_wait = 0;
        wait_req(32'h0000_0600, "two_req600");
        wait_instr(32'h0000_0600, "two_tgt");

        // Redirect to 0x302 while 0x604 is held.
        @(negedge clock);
        bus.instr_ready = 1'b0;
        wait_instr(32'h0000_0604, "mis_hold");
        pulse_redirect(32'h0000_0302);
`ifdef FETCH_MISALIGN_TRAP_EN
        begin
            logic active = 1'b0;
            check("mis_fault",       {31'd0, bus.misalign_fault}, 32'd1);
            check("mis_fault_pc",    bus.misalign_pc, 32'h0000_0302);
            check("mis_req_valid",   {31'd0, bus.imem_req_valid}, 32'd0);
            check("mis_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
            bus.instr_ready = 1'b1;
            pulse_redirect(32'h0000_0700);
            for (int i = 0; i < 8; i++) begin
                @(negedge clock);
                if (bus.imem_req_valid || bus.instr_valid) active = 1'b1;
            end
            check("mis_quiet",  {31'd0, active}, 32'd0);
            check("mis_sticky", {31'd0, bus.misalign_fault}, 32'd1);
        end
`else
        check("mis_fault",       {31'd0, bus.misalign_fault}, 32'd0);
        check("mis_fault_pc",    bus.misalign_pc, 32'd0);
        check("mis_req_valid",   {31'd0, bus.imem_req_valid}, 32'd1);
        check("mis_addr",        bus.imem_addr, 32'h0000_0300);
        check("mis_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
        bus.instr_ready = 1'b1;
        wait_instr(32'h0000_0300, "mis_tgt");
`endif

        // Redirect and instr_ready in the same HOLD cycle, then PC wrap at 2^32.
        do_reset(1'b1);
        wait_instr(32'h0000_0100, "wrap0");
        pulse_redirect(32'hFFFF_FFFC);
        check("wrap_redir_drop", {31'd0, bus.instr_valid}, 32'd0);
        check("wrap_redir_addr", bus.imem_addr, 32'hFFFF_FFFC);
        wait_instr(32'hFFFF_FFFC, "wrap_top");
        wait_req(32'h0000_0000, "wrap_req0");
        wait_instr(32'h0000_0000, "wrap_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
